// File: rtl/radio_slot_sequencer.sv
// radio_slot_sequencer: TX/RX burst sequencer for BTradio; define RADIO_SEQ_RR_EN for round-robin arbitration
module radio_slot_sequencer #(
   parameter int FK_W    = 7,
   parameter int SETUP_W = 10,
   parameter int LEN_W   = 12
) (
   input  logic               clk_6M,
   input  logic               rst,
   input  logic               p_1us,
   input  logic [SETUP_W-1:0] regi_pllsetuptime,
   input  logic               tx_req,
   input  logic               rx_req,
   input  logic [FK_W-1:0]    tx_fk,
   input  logic [FK_W-1:0]    rx_fk,
   input  logic [LEN_W-1:0]   tx_len,
   input  logic [LEN_W-1:0]   rx_len,
   input  logic               cancel_p,
   output logic               tx_grant_p,
   output logic               rx_grant_p,
   output logic [FK_W-1:0]    radio_fk,
   output logic               loadfreq_p,
   output logic               txen,
   output logic               rxen,
   output logic               busy,
   output logic               done_p,
   output logic               abort_p
);
   localparam int CNT_W = (LEN_W > SETUP_W) ? LEN_W : SETUP_W;
   typedef enum logic [2:0] {IDLE, LOAD, SETTLE, ACTIVE, DONE} state_t;
   state_t           state, state_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [FK_W-1:0]  fk_d;
   logic             dir_q, dir_d;
   logic             pick_tx, start, cancel_hit;
`ifdef RADIO_SEQ_RR_EN
   logic rr_rx;
   assign pick_tx = tx_req && !(rx_req && rr_rx);
   always_ff @(posedge clk_6M or posedge rst)
      if (rst) rr_rx <= 1'b0;
      else if (start && tx_req && rx_req) rr_rx <= !rr_rx;
`else
   assign pick_tx = tx_req;
`endif
   assign start      = (state == IDLE) && !done_p && (tx_req || rx_req);
   assign cancel_hit = cancel_p && (state != IDLE) && (state != DONE);
   assign dir_d      = start ? pick_tx : dir_q;
   assign len_d      = start ? (pick_tx ? tx_len : rx_len) : len_q;
   assign fk_d       = start ? (pick_tx ? tx_fk : rx_fk) : radio_fk;
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      case (state)
         IDLE: state_d = start ? LOAD : IDLE;
         LOAD: begin
            state_d = SETTLE;
            cnt_d   = '0;
         end
         SETTLE:
            if (cnt >= CNT_W'(regi_pllsetuptime)) begin
               state_d = (len_q == '0) ? DONE : ACTIVE;
               cnt_d   = '0;
            end else if (p_1us) cnt_d = cnt + CNT_W'(1);
         ACTIVE:
            if (cnt == CNT_W'(len_q)) state_d = DONE;
            else if (p_1us) cnt_d = cnt + CNT_W'(1);
         default: state_d = IDLE;
      endcase
      if (cancel_hit) state_d = IDLE;
   end
   always_ff @(posedge clk_6M or posedge rst)
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         len_q      <= '0;
         dir_q      <= 1'b0;
         radio_fk   <= '0;
         tx_grant_p <= 1'b0;
         rx_grant_p <= 1'b0;
         loadfreq_p <= 1'b0;
         txen       <= 1'b0;
         rxen       <= 1'b0;
         busy       <= 1'b0;
         done_p     <= 1'b0;
         abort_p    <= 1'b0;
      end else begin
         state      <= state_d;
         cnt        <= cnt_d;
         len_q      <= len_d;
         dir_q      <= dir_d;
         radio_fk   <= fk_d;
         tx_grant_p <= start && pick_tx;
         rx_grant_p <= start && !pick_tx;
         loadfreq_p <= start;
         txen       <= (state_d == ACTIVE) && dir_q;
         rxen       <= (state_d == ACTIVE) && !dir_q;
         busy       <= state_d != IDLE;
         done_p     <= state == DONE;
         abort_p    <= cancel_hit;
      end
endmodule

// File: tb/tb_radio_slot_sequencer.sv
// tb_radio_slot_sequencer: directed self-checking bench for radio_slot_sequencer
module tb_radio_slot_sequencer;
   localparam int FK_W = 7, SETUP_W = 10, LEN_W = 12;
   logic               clk_6M = 1'b0;
   logic               rst, p_1us, tx_req, rx_req, cancel_p;
   logic [SETUP_W-1:0] regi_pllsetuptime;
   logic [FK_W-1:0]    tx_fk, rx_fk;
   logic [LEN_W-1:0]   tx_len, rx_len;
   logic               tx_grant_p, rx_grant_p, loadfreq_p, txen, rxen, busy, done_p, abort_p;
   logic [FK_W-1:0]    radio_fk;
   int                 tests = 0;
   int                 fails = 0;

   radio_slot_sequencer #(.FK_W(FK_W), .SETUP_W(SETUP_W), .LEN_W(LEN_W)) dut (
      .clk_6M(clk_6M), .rst(rst), .p_1us(p_1us), .regi_pllsetuptime(regi_pllsetuptime),
      .tx_req(tx_req), .rx_req(rx_req), .tx_fk(tx_fk), .rx_fk(rx_fk),
      .tx_len(tx_len), .rx_len(rx_len), .cancel_p(cancel_p),
      .tx_grant_p(tx_grant_p), .rx_grant_p(rx_grant_p), .radio_fk(radio_fk),
      .loadfreq_p(loadfreq_p), .txen(txen), .rxen(rxen), .busy(busy),
      .done_p(done_p), .abort_p(abort_p)
   );

   always #5 clk_6M = ~clk_6M;

   initial begin
      p_1us = 1'b0;
      forever begin
         repeat (5) @(posedge clk_6M);
         #1 p_1us = 1'b1;
         @(posedge clk_6M);
         #1 p_1us = 1'b0;
      end
   end

   task automatic wait_idle(input string name);
      int n = 0;
      while ((busy || done_p || abort_p) && n < 6000) begin
         @(negedge clk_6M);
         n++;
      end
      tests++;
      if (busy || done_p || abort_p) begin
         fails++;
         $display("FAIL %s_idle: busy=%0b done_p=%0b abort_p=%0b, required all 0", name, busy, done_p, abort_p);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tx_req = 1'b0;
      rx_req = 1'b0;
      cancel_p = 1'b0;
      regi_pllsetuptime = '0;
      tx_fk = '0;
      rx_fk = '0;
      tx_len = '0;
      rx_len = '0;
      repeat (3) @(negedge clk_6M);
      tests++;
      if ({tx_grant_p, rx_grant_p, loadfreq_p, txen, rxen, busy, done_p, abort_p} !== 8'b0) begin
         fails++;
         $display("FAIL reset_outputs: got %b required 00000000",
                  {tx_grant_p, rx_grant_p, loadfreq_p, txen, rxen, busy, done_p, abort_p});
      end
      tests++;
      if (radio_fk !== 7'd0) begin
         fails++;
         $display("FAIL reset_fk: got %0d required 0", radio_fk);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk_6M);
      tests++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL reset_idle_busy: got %b required 0", busy);
      end
   endtask

   task automatic test_basic_tx();
      int n = 0, tg = 0, rg = 0, lf = 0, fk = 0, st = 0, at = 0, dn = 0;
      logic rx_seen = 1'b0, tx_seen = 1'b0;
      regi_pllsetuptime = 10'd150;
      tx_fk = 7'd23;
      rx_fk = 7'd99;
      tx_len = 12'd366;
      tx_req = 1'b1;
      while (dn == 0 && n < 4000) begin
         @(negedge clk_6M);
         n++;
         if (tx_grant_p) begin
            tg++;
            tx_req = 1'b0;
         end
         if (rx_grant_p) rg++;
         if (loadfreq_p) begin
            lf++;
            fk = int'(radio_fk);
         end
         if (rxen) rx_seen = 1'b1;
         if (txen) begin
            tx_seen = 1'b1;
            if (p_1us) at++;
         end else if (busy && !loadfreq_p && !tx_seen && p_1us) st++;
         if (done_p) dn++;
      end
      tests++;
      if (tg !== 1) begin fails++; $display("FAIL basic_tx_grant: got %0d pulses required 1", tg); end
      tests++;
      if (rg !== 0) begin fails++; $display("FAIL basic_rx_grant: got %0d pulses required 0", rg); end
      tests++;
      if (lf !== 1) begin fails++; $display("FAIL basic_loadfreq: got %0d pulses required 1", lf); end
      tests++;
      if (fk !== 23) begin fails++; $display("FAIL basic_fk: got %0d required 23", fk); end
      tests++;
      if (st !== 150) begin fails++; $display("FAIL basic_settle_ticks: got %0d required 150", st); end
      tests++;
      if (at !== 366) begin fails++; $display("FAIL basic_active_ticks: got %0d required 366", at); end
      tests++;
      if (rx_seen !== 1'b0) begin fails++; $display("FAIL basic_rxen: got %b required 0", rx_seen); end
      tests++;
      if (dn !== 1) begin fails++; $display("FAIL basic_done: got %0d required 1", dn); end
      wait_idle("basic");
   endtask

   task automatic test_arb();
      int n = 0, g = 0;
      int t[3];
      int f[3];
      logic [2:0] order = 3'b000;
      logic [2:0] exp_order;
      int exp_fk1;
`ifdef RADIO_SEQ_RR_EN
      exp_order = 3'b010;
      exp_fk1 = 44;
`else
      exp_order = 3'b000;
      exp_fk1 = 11;
`endif
      regi_pllsetuptime = '0;
      tx_len = '0;
      rx_len = '0;
      tx_fk = 7'd11;
      rx_fk = 7'd44;
      tx_req = 1'b1;
      rx_req = 1'b1;
      while (g < 3 && n < 200) begin
         @(negedge clk_6M);
         n++;
         if (tx_grant_p || rx_grant_p) begin
            order[g] = rx_grant_p;
            t[g] = n;
            f[g] = int'(radio_fk);
            g++;
         end
      end
      tx_req = 1'b0;
      rx_req = 1'b0;
      tests++;
      if (g !== 3) begin fails++; $display("FAIL arb_count: got %0d grants required 3", g); end
      else begin
         tests++;
         if (order !== exp_order) begin fails++; $display("FAIL arb_order: got %b required %b (1=RX)", order, exp_order); end
         tests++;
         if (t[1] - t[0] !== 5) begin fails++; $display("FAIL arb_gap1: got %0d cycles required 5", t[1] - t[0]); end
         tests++;
         if (t[2] - t[1] !== 5) begin fails++; $display("FAIL arb_gap2: got %0d cycles required 5", t[2] - t[1]); end
         tests++;
         if (f[1] !== exp_fk1) begin fails++; $display("FAIL arb_fk: got %0d required %0d", f[1], exp_fk1); end
      end
      wait_idle("arb");
   endtask

   task automatic test_zero();
      int n = 0, g_at = -100, d_at = -1, fk = 0;
      logic en = 1'b0;
      regi_pllsetuptime = '0;
      rx_len = '0;
      rx_fk = 7'd77;
      rx_req = 1'b1;
      while (d_at < 0 && n < 100) begin
         @(negedge clk_6M);
         n++;
         if (rx_grant_p) begin
            g_at = n;
            fk = int'(radio_fk);
            rx_req = 1'b0;
         end
         if (txen || rxen) en = 1'b1;
         if (done_p) d_at = n;
      end
      tests++;
      if (d_at - g_at !== 3) begin fails++; $display("FAIL zero_done_delay: got %0d cycles required 3", d_at - g_at); end
      tests++;
      if (en !== 1'b0) begin fails++; $display("FAIL zero_enable: got %b required 0", en); end
      tests++;
      if (fk !== 77) begin fails++; $display("FAIL zero_fk: got %0d required 77", fk); end
      wait_idle("zero");
   endtask

   task automatic test_cancel_active();
      int n = 0, ticks = 0;
      regi_pllsetuptime = 10'd2;
      rx_len = 12'd100;
      rx_fk = 7'd5;
      tx_fk = 7'd9;
      tx_len = 12'd3;
      rx_req = 1'b1;
      while (!rx_grant_p && n < 100) begin
         @(negedge clk_6M);
         n++;
      end
      rx_req = 1'b0;
      tx_req = 1'b1;
      while (ticks < 50 && n < 2000) begin
         @(negedge clk_6M);
         n++;
         if (rxen && p_1us) ticks++;
      end
      tests++;
      if (ticks !== 50 || rxen !== 1'b1) begin fails++; $display("FAIL cancel_reach: ticks=%0d rxen=%b required 50 and 1", ticks, rxen); end
      tests++;
      if (radio_fk !== 7'd5) begin fails++; $display("FAIL cancel_fk_hold: got %0d required 5", radio_fk); end
      cancel_p = 1'b1;
      @(negedge clk_6M);
      cancel_p = 1'b0;
      tests++;
      if ({rxen, abort_p, done_p, busy, tx_grant_p} !== 5'b01000) begin
         fails++;
         $display("FAIL cancel_response: rxen/abort/done/busy/grant got %b required 01000", {rxen, abort_p, done_p, busy, tx_grant_p});
      end
      @(negedge clk_6M);
      tests++;
      if (tx_grant_p !== 1'b1) begin fails++; $display("FAIL cancel_next_grant: got %b required 1", tx_grant_p); end
      tests++;
      if (radio_fk !== 7'd9) begin fails++; $display("FAIL cancel_next_fk: got %0d required 9", radio_fk); end
      tx_req = 1'b0;
      wait_idle("cancel_active");
   endtask

   task automatic test_cancel_done();
      int n = 0;
      logic seen = 1'b0, hit = 1'b0;
      regi_pllsetuptime = '0;
      tx_len = 12'd1;
      tx_req = 1'b1;
      while (!hit && n < 100) begin
         @(negedge clk_6M);
         n++;
         if (tx_grant_p) tx_req = 1'b0;
         if (txen) seen = 1'b1;
         else if (seen && busy) begin
            hit = 1'b1;
            cancel_p = 1'b1;
         end
      end
      @(negedge clk_6M);
      cancel_p = 1'b0;
      tests++;
      if ({hit, done_p, abort_p, busy} !== 4'b1100) begin
         fails++;
         $display("FAIL cancel_done: hit/done/abort/busy got %b required 1100", {hit, done_p, abort_p, busy});
      end
      wait_idle("cancel_done");
   endtask

   task automatic test_reset_mid_settle();
      int n = 0, tg = 0, dn = 0;
      logic seen = 1'b0;
      regi_pllsetuptime = 10'd100;
      tx_len = 12'd2;
      tx_fk = 7'd3;
      tx_req = 1'b1;
      while (!loadfreq_p && n < 100) begin
         @(negedge clk_6M);
         n++;
      end
      repeat (5) @(negedge clk_6M);
      tests++;
      if (busy !== 1'b1) begin fails++; $display("FAIL rst_settle_busy: got %b required 1", busy); end
      rst = 1'b1;
      #1;
      tests++;
      if ({tx_grant_p, rx_grant_p, loadfreq_p, txen, rxen, busy, done_p, abort_p, radio_fk} !== 15'd0) begin
         fails++;
         $display("FAIL rst_async: got %b required all 0",
                  {tx_grant_p, rx_grant_p, loadfreq_p, txen, rxen, busy, done_p, abort_p, radio_fk});
      end
      regi_pllsetuptime = '0;
      @(negedge clk_6M);
      rst = 1'b0;
      n = 0;
      while (dn == 0 && n < 200) begin
         @(negedge clk_6M);
         n++;
         if (tx_grant_p) begin
            tg++;
            tx_req = 1'b0;
         end
         if (txen) seen = 1'b1;
         if (done_p) dn++;
      end
      tests++;
      if ({tg, dn} !== {32'd1, 32'd1} || seen !== 1'b1) begin
         fails++;
         $display("FAIL rst_recover: grants=%0d done=%0d txen_seen=%b required 1 1 1", tg, dn, seen);
      end
      wait_idle("rst_recover");
   endtask

   initial begin
      test_reset();
      test_basic_tx();
      test_arb();
      test_zero();
      test_cancel_active();
      test_cancel_done();
      test_reset_mid_settle();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
